// File: rtl/mem_wb_pkg.sv
// Shared pipeline definitions for the MEM/WB boundary: load-size codes and the hard-wired zero register.
package mem_wb_pkg;
  typedef enum logic [1:0] {
    TAM_WORD = 2'b00,
    TAM_HALF = 2'b01,
    TAM_BYTE = 2'b10
  } tam_carga_e;

  localparam logic [4:0] REG_CERO = 5'd0;
endpackage

// File: rtl/mem_wb_extractor_carga.sv
// Big-endian lane select plus sign/zero extension of a loaded word; also flags misaligned accesses.
module extractor_carga
  import mem_wb_pkg::*;
(
  input  logic [1:0]  tam,
  input  logic        signo,
  input  logic [1:0]  offset,
  input  logic [31:0] dato,
  output logic [31:0] valor,
  output logic        desalineado
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b           = 8'h00;
    h           = 16'h0000;
    valor       = dato;
    desalineado = 1'b0;
    // offset 0 is the most significant lane
    case (offset)
      2'd0:    b = dato[31:24];
      2'd1:    b = dato[23:16];
      2'd2:    b = dato[15:8];
      default: b = dato[7:0];
    endcase
    h = offset[1] ? dato[15:0] : dato[31:16];
    case (tam_carga_e'(tam))
      TAM_HALF: begin
        valor       = {{16{signo & h[15]}}, h};
        desalineado = offset[0];
      end
      TAM_BYTE: valor = {{24{signo & b[7]}}, b};
      default:  desalineado = (offset != 2'd0);
    endcase
  end
endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: selects load/ALU write data, gates the register write, counts retirements.
module mem_wb
  import mem_wb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_MEM,
  input  logic        reg_escribir_MEM,
  input  logic        mem_a_reg_MEM,
  input  logic [1:0]  tam_carga_MEM,
  input  logic        carga_signo_MEM,
  input  logic [31:0] alu_resultado_MEM,
  input  logic [31:0] dato_memoria_MEM,
  input  logic [4:0]  registro_destino_MEM,
  output logic        reg_escribir_WB,
  output logic [31:0] write_data_WB,
  output logic [4:0]  registro_destino_WB,
  output logic        valid_WB,
  output logic        desalineado_WB,
  output logic [31:0] contador_retiradas
);
  logic [31:0] valor_carga;
  logic        desal_carga;
  logic        desal_n;
  logic        we_n;

  extractor_carga u_ext (
    .tam         (tam_carga_MEM),
    .signo       (carga_signo_MEM),
    .offset      (alu_resultado_MEM[1:0]),
    .dato        (dato_memoria_MEM),
    .valor       (valor_carga),
    .desalineado (desal_carga)
  );

  // misalignment only matters for real memory loads
  assign desal_n = valid_MEM & mem_a_reg_MEM & desal_carga;
  assign we_n    = valid_MEM & reg_escribir_MEM & (registro_destino_MEM != REG_CERO) & ~desal_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_escribir_WB     <= 1'b0;
      write_data_WB       <= '0;
      registro_destino_WB <= '0;
      valid_WB            <= 1'b0;
      desalineado_WB      <= 1'b0;
      contador_retiradas  <= '0;
    end else begin
      // the instruction sitting in WB retires when it is allowed to leave
      if (valid_WB && !stall && !flush)
        contador_retiradas <= contador_retiradas + 32'd1;
      if (flush) begin
        reg_escribir_WB     <= 1'b0;
        write_data_WB       <= '0;
        registro_destino_WB <= '0;
        valid_WB            <= 1'b0;
        desalineado_WB      <= 1'b0;
      end else if (!stall) begin
        reg_escribir_WB     <= we_n;
        write_data_WB       <= mem_a_reg_MEM ? valor_carga : alu_resultado_MEM;
        registro_destino_WB <= registro_destino_MEM;
        valid_WB            <= valid_MEM;
        desalineado_WB      <= desal_n;
      end
    end
  end
endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb: hand-computed vectors for ALU/load paths, stall/flush, counter and reset.
module tb_mem_wb;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, flush, valid_MEM, reg_escribir_MEM, mem_a_reg_MEM, carga_signo_MEM;
  logic [1:0]  tam_carga_MEM;
  logic [31:0] alu_resultado_MEM, dato_memoria_MEM;
  logic [4:0]  registro_destino_MEM;
  logic        reg_escribir_WB, valid_WB, desalineado_WB;
  logic [31:0] write_data_WB, contador_retiradas;
  logic [4:0]  registro_destino_WB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .stall                (stall),
    .flush                (flush),
    .valid_MEM            (valid_MEM),
    .reg_escribir_MEM     (reg_escribir_MEM),
    .mem_a_reg_MEM        (mem_a_reg_MEM),
    .tam_carga_MEM        (tam_carga_MEM),
    .carga_signo_MEM      (carga_signo_MEM),
    .alu_resultado_MEM    (alu_resultado_MEM),
    .dato_memoria_MEM     (dato_memoria_MEM),
    .registro_destino_MEM (registro_destino_MEM),
    .reg_escribir_WB      (reg_escribir_WB),
    .write_data_WB        (write_data_WB),
    .registro_destino_WB  (registro_destino_WB),
    .valid_WB             (valid_WB),
    .desalineado_WB       (desalineado_WB),
    .contador_retiradas   (contador_retiradas)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic [31:0] wd, input logic [4:0] rd,
                        input logic we, input logic v, input logic ds, input logic [31:0] cnt);
    chk({tag, ".wd"},    write_data_WB, wd);
    chk({tag, ".rd"},    {27'd0, registro_destino_WB}, {27'd0, rd});
    chk({tag, ".we"},    {31'd0, reg_escribir_WB}, {31'd0, we});
    chk({tag, ".valid"}, {31'd0, valid_WB}, {31'd0, v});
    chk({tag, ".desal"}, {31'd0, desalineado_WB}, {31'd0, ds});
    chk({tag, ".cnt"},   contador_retiradas, cnt);
  endtask

  task automatic drive(input logic v, input logic we, input logic m2r, input logic [1:0] tam,
                       input logic sg, input logic [31:0] alu, input logic [31:0] dat, input logic [4:0] rd);
    valid_MEM = v; reg_escribir_MEM = we; mem_a_reg_MEM = m2r; tam_carga_MEM = tam;
    carga_signo_MEM = sg; alu_resultado_MEM = alu; dato_memoria_MEM = dat; registro_destino_MEM = rd;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'hAAAA_5555, 32'h0, 5'd3);
    edge1();
    chk_wb("reset", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    reset_n = 1'b1;

    // ALU path
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF, 5'd5);
    edge1(); chk_wb("alu", 32'h0000_1234, 5'd5, 1'b1, 1'b1, 1'b0, 32'd0);

    // byte loads
    drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 32'h0000_0100, 32'h80FF_7F01, 5'd6);
    edge1(); chk_wb("byte_s0", 32'hFFFF_FF80, 5'd6, 1'b1, 1'b1, 1'b0, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0101, 32'h80FF_7F01, 5'd6);
    edge1(); chk_wb("byte_u1", 32'h0000_00FF, 5'd6, 1'b1, 1'b1, 1'b0, 32'd2);
    drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 32'h0000_0102, 32'h80FF_7F01, 5'd6);
    edge1(); chk_wb("byte_s2", 32'h0000_007F, 5'd6, 1'b1, 1'b1, 1'b0, 32'd3);
    drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 32'h0000_0103, 32'h80FF_7F01, 5'd6);
    edge1(); chk_wb("byte_s3", 32'h0000_0001, 5'd6, 1'b1, 1'b1, 1'b0, 32'd4);

    // half loads
    drive(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 32'h0000_0202, 32'h8001_ABCD, 5'd7);
    edge1(); chk_wb("half_s2", 32'hFFFF_ABCD, 5'd7, 1'b1, 1'b1, 1'b0, 32'd5);
    drive(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0200, 32'h8001_ABCD, 5'd7);
    edge1(); chk_wb("half_u0", 32'h0000_8001, 5'd7, 1'b1, 1'b1, 1'b0, 32'd6);
    drive(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 32'h0000_0201, 32'h8001_ABCD, 5'd7);
    edge1();
    chk("half_mis.desal", {31'd0, desalineado_WB}, 32'd1);
    chk("half_mis.we", {31'd0, reg_escribir_WB}, 32'd0);
    chk("half_mis.cnt", contador_retiradas, 32'd7);

    // word loads, including code 11
    drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 32'h0000_0300, 32'hDEAD_BEEF, 5'd8);
    edge1(); chk_wb("word0", 32'hDEAD_BEEF, 5'd8, 1'b1, 1'b1, 1'b0, 32'd8);
    drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 32'h0000_0302, 32'hDEAD_BEEF, 5'd8);
    edge1();
    chk("word_mis.desal", {31'd0, desalineado_WB}, 32'd1);
    chk("word_mis.we", {31'd0, reg_escribir_WB}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 32'h0000_0304, 32'h1234_5678, 5'd8);
    edge1(); chk_wb("word11", 32'h1234_5678, 5'd8, 1'b1, 1'b1, 1'b0, 32'd10);

    // stall for three edges with different inputs presented
    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0999, 32'h0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      edge1(); chk_wb("stall", 32'h1234_5678, 5'd8, 1'b1, 1'b1, 1'b0, 32'd10);
    end
    stall = 1'b0;
    edge1(); chk_wb("unstall", 32'h0000_0999, 5'd9, 1'b1, 1'b1, 1'b0, 32'd11);

    // stall and flush together: flush wins, no retirement
    stall = 1'b1; flush = 1'b1;
    edge1(); chk_wb("stall_flush", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd11);
    stall = 1'b0; flush = 1'b0;

    // rd=0 suppresses the write but still retires
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0055, 32'h0, 5'd0);
    edge1(); chk_wb("rd0", 32'h0000_0055, 5'd0, 1'b0, 1'b1, 1'b0, 32'd11);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0066, 32'h0, 5'd3);
    edge1(); chk_wb("invalid", 32'h0000_0066, 5'd3, 1'b0, 1'b0, 1'b0, 32'd12);

    // counter wrap
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0077, 32'h0, 5'd9);
    edge1(); chk("pre_wrap.cnt", contador_retiradas, 32'd12);
    force dut.contador_retiradas = 32'hFFFF_FFFF;
    #1;
    release dut.contador_retiradas;
    chk("preset.cnt", contador_retiradas, 32'hFFFF_FFFF);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0088, 32'h0, 5'd10);
    edge1(); chk_wb("wrap", 32'h0000_0088, 5'd10, 1'b1, 1'b1, 1'b0, 32'd0);
    edge1(); chk("post_wrap.cnt", contador_retiradas, 32'd1);

    // asynchronous reset between edges
    drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 32'h0000_0301, 32'hCAFE_F00D, 5'd11);
    edge1(); chk("pre_rst.desal", {31'd0, desalineado_WB}, 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_wb("async_rst", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    reset_n = 1'b1;
    edge1(); chk_wb("post_rst", 32'hCAFE_F00D, 5'd11, 1'b0, 1'b1, 1'b1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous, active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 stall  input  1  hold the current WB contents.
REQ-005 flush  input  1  load a bubble (invalid, no write).
REQ-006 valid_MEM  input  1  MEM stage holds a real instruction.
REQ-007 reg_escribir_MEM  input  1  instruction writes the register bank.
REQ-008 mem_a_reg_MEM  input  1  write source: 1 = memory data, 0 = ALU result.
REQ-009 tam_carga_MEM  input  2  load size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-010 carga_signo_MEM  input  1  1 = sign-extend, 0 = zero-extend half/byte loads.
REQ-011 alu_resultado_MEM  input  32  ALU result and load address.
REQ-012 dato_memoria_MEM  input  32  word read from data memory, big-endian.
REQ-013 registro_destino_MEM  input  5  destination register number.
REQ-014 reg_escribir_WB  output  1  registered write enable toward WB.
REQ-015 write_data_WB  output  32  registered final write data.
REQ-016 registro_destino_WB  output  5  registered destination number.
REQ-017 valid_WB  output  1  WB holds a real instruction.
REQ-018 desalineado_WB  output  1  WB instruction was a misaligned load.
REQ-019 contador_retiradas  output  32  count of retired instructions.

Function
REQ-020 Update priority on each rising clk edge SHALL be: flush > stall > normal load.
REQ-021 flush SHALL set valid_WB=0, reg_escribir_WB=0 and desalineado_WB=0, clear write_data_WB and registro_destino_WB to 0, and win over a simultaneous stall.
REQ-022 stall without flush SHALL hold all WB outputs unchanged.
REQ-023 Normal load SHALL register the MEM inputs with 1-cycle latency.
REQ-024 Address offset SHALL be alu_resultado_MEM[1:0]; byte offset 0 SHALL select bits 31:24 and offset 3 SHALL select bits 7:0 (big-endian).
REQ-025 Half offset 0 SHALL select bits 31:16 and offset 2 SHALL select bits 15:0.
REQ-026 Byte and half values SHALL be extended to 32 bits by sign or by zero according to carga_signo_MEM.
REQ-027 When mem_a_reg_MEM=0, write_data_WB SHALL be alu_resultado_MEM and size/offset SHALL be ignored.
REQ-028 A memory load is misaligned if half has offset[0]=1 or word has offset!=0; then desalineado_WB SHALL be 1 and reg_escribir_WB SHALL be 0.
REQ-029 reg_escribir_WB SHALL be 0 when registro_destino_MEM=0 or valid_MEM=0.
REQ-030 contador_retiradas SHALL increment by 1 on each edge where valid_WB=1 and stall=0, wrap from 0xFFFFFFFF to 0, and not increment on a flushed or stalled cycle.

Reset
REQ-031 Asserting reset_n=0 SHALL immediately clear every output and the counter to 0, regardless of clk, stall or flush.
REQ-032 The first edge after reset release SHALL behave as a normal load, stall or flush.

Structure
REQ-033 Load-size codes (00/01/10) and the register-zero constant SHALL live in the shared pipeline package.
REQ-034 Load extraction and extension SHALL be one combinational sub-module, extractor_carga; the registers and the counter stay in mem_wb.

Verification
REQ-035 ALU path test: alu=0x00001234, mem_a_reg=0, rd=5, valid=1 -> next cycle write_data_WB=0x00001234, rd_out=5, reg_escribir_WB=1.
REQ-036 Byte load test: dato=0x80FF7F01, byte, signed, offset 0 -> 0xFFFFFF80; unsigned offset 1 -> 0x000000FF; signed offset 2 -> 0x0000007F.
REQ-037 Half load test: dato=0x8001ABCD, signed, offset 2 -> 0xFFFFABCD; half offset 1 -> desalineado_WB=1, reg_escribir_WB=0.
REQ-038 Stall/flush test: hold stall for 3 cycles -> outputs unchanged and counter frozen; stall+flush together -> valid_WB=0, reg_escribir_WB=0.
REQ-039 Counter and rd=0 test: preset 0xFFFFFFFF then retire one -> counter 0; rd=0 with reg_escribir=1 -> reg_escribir_WB=0 and the counter still increments.
REQ-040 Async reset test: drop reset_n mid-cycle between edges -> all outputs 0 before the next edge.
